mem_port_arbiter: RTL and testbench

- Shares the single synchronous data-memory port between the pipelined CPU's memory stage and a secondary DMA/accelerator master.
- CPU has default priority. The DMA master is guaranteed forward progress by a starvation counter and a bounded burst window.
- When the CPU loses arbitration, the block asserts cpu_stall, which the top level ANDs into the CPU enable. A hold register keeps CPU read data stable across a stall.

---
 rtl/mem_port_arbiter.sv | 100 ++++++++++
 tb/tb_mem_port_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous memory port between the CPU memory stage and a DMA master.
// Define MEM_ARB_STATS_EN to build the stall/grant statistic counters.
module mem_port_arbiter #(
    parameter int DMA_MAX_WAIT = 4,
    parameter int DMA_BURST    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  cpu_mem_write_en,
    input  logic        cpu_mem_read_en,
    input  logic [31:0] cpu_mem_addr,
    input  logic [31:0] cpu_mem_write_data,
    output logic [31:0] cpu_mem_read_data,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic [3:0]  dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,
    output logic [3:0]  mem_write_en,
    output logic        mem_read_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic [31:0] stat_cpu_stall_cnt,
    output logic [31:0] stat_dma_grant_cnt
);
    typedef enum logic {CPU_PRI, DMA_PRI} state_t;
    state_t      state_q, state_d;
    logic [7:0]  wait_q, wait_d, burst_q, burst_d;
    logic        cpu_req, cpu_gnt;
    logic        rd_dma_q, rd_cpu_q, hold_v;
    logic [31:0] hold_q;
    // Grants are gated by rst so every control output drops the instant reset asserts.
    assign cpu_req   = cpu_mem_read_en | (|cpu_mem_write_en);
    assign dma_gnt   = rst & dma_req & ((state_q == DMA_PRI) | ~cpu_req);
    assign cpu_gnt   = rst & cpu_req & ~dma_gnt;
    assign cpu_stall = rst & cpu_req & ~cpu_gnt;
    assign mem_addr       = dma_gnt ? dma_addr : cpu_mem_addr;
    assign mem_write_data = dma_gnt ? dma_wdata : cpu_mem_write_data;
    assign mem_write_en   = dma_gnt ? dma_we : (cpu_gnt ? cpu_mem_write_en : 4'b0);
    assign mem_read_en    = dma_gnt ? ~(|dma_we) : (cpu_gnt & cpu_mem_read_en);
    assign dma_rvalid        = rst & rd_dma_q;
    assign dma_rdata         = mem_read_data;
    assign cpu_mem_read_data = hold_v ? hold_q : mem_read_data;
    always_comb begin
        state_d = state_q;
        wait_d  = 8'd0;
        burst_d = 8'd0;
        if (state_q == CPU_PRI) begin
            if (dma_req && !dma_gnt) begin
                if (int'(wait_q) + 1 >= DMA_MAX_WAIT) state_d = DMA_PRI;
                else wait_d = wait_q + 8'd1;
            end
        end else if (!dma_req || (dma_gnt && cpu_req && int'(burst_q) + 1 >= DMA_BURST)) begin
            state_d = CPU_PRI;
        end else begin
            burst_d = (dma_gnt && cpu_req) ? burst_q + 8'd1 : burst_q;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= CPU_PRI;
            wait_q   <= 8'd0;
            burst_q  <= 8'd0;
            rd_dma_q <= 1'b0;
            rd_cpu_q <= 1'b0;
            hold_v   <= 1'b0;
            hold_q   <= 32'd0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            burst_q  <= burst_d;
            rd_dma_q <= dma_gnt & ~(|dma_we);
            rd_cpu_q <= cpu_gnt & cpu_mem_read_en;
            if (rd_cpu_q && cpu_stall) begin
                hold_q <= mem_read_data;
                hold_v <= 1'b1;
            end else if (!cpu_stall) begin
                hold_v <= 1'b0;
            end
        end
    end
`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_cpu_stall_cnt <= 32'd0;
            stat_dma_grant_cnt <= 32'd0;
        end else begin
            if (cpu_stall && stat_cpu_stall_cnt != 32'hFFFF_FFFF) stat_cpu_stall_cnt <= stat_cpu_stall_cnt + 32'd1;
            if (dma_gnt && stat_dma_grant_cnt != 32'hFFFF_FFFF) stat_dma_grant_cnt <= stat_dma_grant_cnt + 32'd1;
        end
    end
`else
    assign stat_cpu_stall_cnt = 32'd0;
    assign stat_dma_grant_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus hand sequences for mem_port_arbiter.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  cpu_mem_write_en = 4'b0;
    logic        cpu_mem_read_en = 1'b0;
    logic [31:0] cpu_mem_addr = 32'd0;
    logic [31:0] cpu_mem_write_data = 32'h1111_1111;
    logic [31:0] cpu_mem_read_data;
    logic        cpu_stall;
    logic        dma_req = 1'b0;
    logic [3:0]  dma_we = 4'b0;
    logic [31:0] dma_addr = 32'd0;
    logic [31:0] dma_wdata = 32'h2222_2222;
    logic        dma_gnt, dma_rvalid;
    logic [31:0] dma_rdata;
    logic [3:0]  mem_write_en;
    logic        mem_read_en;
    logic [31:0] mem_addr, mem_write_data;
    logic [31:0] mem_read_data = 32'd0;
    logic [31:0] stat_cpu_stall_cnt, stat_dma_grant_cnt;
    int tests = 0;
    int fails = 0;
`ifdef MEM_ARB_STATS_EN
    localparam logic [31:0] EXP_STAT = 32'd4;
`else
    localparam logic [31:0] EXP_STAT = 32'd0;
`endif
    mem_port_arbiter #(.DMA_MAX_WAIT(4), .DMA_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_mem_write_en(cpu_mem_write_en), .cpu_mem_read_en(cpu_mem_read_en),
        .cpu_mem_addr(cpu_mem_addr), .cpu_mem_write_data(cpu_mem_write_data),
        .cpu_mem_read_data(cpu_mem_read_data), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_write_en(mem_write_en), .mem_read_en(mem_read_en), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
        .stat_cpu_stall_cnt(stat_cpu_stall_cnt), .stat_dma_grant_cnt(stat_dma_grant_cnt)
    );
    always #5 clk = ~clk;
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (mem_read_en) mem_read_data <= mem[mem_addr[11:2]];
        for (int b = 0; b < 4; b++)
            if (mem_write_en[b]) mem[mem_addr[11:2]][b*8 +: 8] <= mem_write_data[b*8 +: 8];
    end
    typedef struct packed {
        logic [3:0]  cwe;
        logic        cre;
        logic [31:0] caddr;
        logic        dreq;
        logic [3:0]  dwe;
        logic [31:0] daddr;
        logic        stall;
        logic        gnt;
        logic        mre;
        logic [3:0]  mwe;
        logic [31:0] maddr;
        logic        rv;
        logic [31:0] rdata;
    } vec_t;
    vec_t v [12];
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask
    task automatic drive(input logic [3:0] cwe, input logic cre, input logic [31:0] caddr,
                         input logic dreq, input logic [3:0] dwe, input logic [31:0] daddr);
        @(negedge clk);
        cpu_mem_write_en = cwe;
        cpu_mem_read_en  = cre;
        cpu_mem_addr     = caddr;
        dma_req          = dreq;
        dma_we           = dwe;
        dma_addr         = daddr;
        #2;
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        cpu_mem_write_en = 4'b0;
        cpu_mem_read_en  = 1'b0;
        dma_req          = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask
    task automatic run_row(input int i);
        drive(v[i].cwe, v[i].cre, v[i].caddr, v[i].dreq, v[i].dwe, v[i].daddr);
        chk($sformatf("row%0d cpu_stall", i), {31'd0, cpu_stall}, {31'd0, v[i].stall});
        chk($sformatf("row%0d dma_gnt", i), {31'd0, dma_gnt}, {31'd0, v[i].gnt});
        chk($sformatf("row%0d mem_read_en", i), {31'd0, mem_read_en}, {31'd0, v[i].mre});
        chk($sformatf("row%0d mem_write_en", i), {28'd0, mem_write_en}, {28'd0, v[i].mwe});
        chk($sformatf("row%0d mem_addr", i), mem_addr, v[i].maddr);
        chk($sformatf("row%0d dma_rvalid", i), {31'd0, dma_rvalid}, {31'd0, v[i].rv});
        if (v[i].rv) chk($sformatf("row%0d dma_rdata", i), dma_rdata, v[i].rdata);
    endtask
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[32'h100 >> 2] = 32'hDEAD_BEEF;
        mem[32'h200 >> 2] = 32'h1234_5678;
        mem[32'h300 >> 2] = 32'hCAFE_F00D;
        //        cwe  cre caddr   dreq dwe  daddr    stall gnt mre mwe  maddr   rv rdata
        v[0] = {4'h0, 1'b0, 32'h0,  1'b1, 4'h0, 32'h100, 1'b0, 1'b1, 1'b1, 4'h0, 32'h100, 1'b0, 32'h0};
        v[1] = {4'h0, 1'b0, 32'h0,  1'b0, 4'h0, 32'h0,   1'b0, 1'b0, 1'b0, 4'h0, 32'h0,   1'b1, 32'hDEAD_BEEF};
        for (int i = 2; i < 12; i++) begin
            v[i] = {4'hF, 1'b0, 32'h40, 1'b1, 4'hF, 32'h80, 1'b0, 1'b0, 1'b0, 4'hF, 32'h40, 1'b0, 32'h0};
            if (i >= 6 && i <= 9) begin
                v[i].stall = 1'b1;
                v[i].gnt   = 1'b1;
                v[i].maddr = 32'h80;
            end
        end
        v[11].dreq = 1'b0;
        #2;
        chk("reset cpu_stall", {31'd0, cpu_stall}, 32'd0);
        chk("reset dma_gnt", {31'd0, dma_gnt}, 32'd0);
        chk("reset dma_rvalid", {31'd0, dma_rvalid}, 32'd0);
        do_reset();
        for (int i = 0; i < 2; i++) run_row(i);
        do_reset();
        for (int i = 2; i < 12; i++) run_row(i);
        chk("stat_cpu_stall_cnt", stat_cpu_stall_cnt, EXP_STAT);
        chk("stat_dma_grant_cnt", stat_dma_grant_cnt, EXP_STAT);
        // CPU read held across a DMA-priority stall.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(4'h0, 1'b1, 32'h200, 1'b1, 4'h0, 32'h300);
            chk("hold pre cpu_stall", {31'd0, cpu_stall}, 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            drive(4'h0, 1'b1, 32'h200, 1'b1, 4'h0, 32'h300);
            chk("hold cpu_stall", {31'd0, cpu_stall}, 32'd1);
            chk("hold dma_gnt", {31'd0, dma_gnt}, 32'd1);
            chk("hold cpu_mem_read_data", cpu_mem_read_data, 32'h1234_5678);
            if (i > 0) chk("hold dma_rdata", dma_rdata, 32'hCAFE_F00D);
        end
        drive(4'h0, 1'b1, 32'h200, 1'b0, 4'h0, 32'h300);
        chk("unstall cpu_stall", {31'd0, cpu_stall}, 32'd0);
        chk("unstall cpu_mem_read_data", cpu_mem_read_data, 32'h1234_5678);
        chk("unstall dma_rvalid", {31'd0, dma_rvalid}, 32'd1);
        chk("unstall dma_rdata", dma_rdata, 32'hCAFE_F00D);
        // Simultaneous first requests: CPU wins.
        do_reset();
        drive(4'b1000, 1'b0, 32'h40, 1'b1, 4'hF, 32'h80);
        chk("simul cpu_stall", {31'd0, cpu_stall}, 32'd0);
        chk("simul dma_gnt", {31'd0, dma_gnt}, 32'd0);
        chk("simul mem_write_en", {28'd0, mem_write_en}, 32'h8);
        chk("simul mem_addr", mem_addr, 32'h40);
        // Reset in the middle of a DMA burst.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(4'hF, 1'b0, 32'h40, 1'b1, 4'h0, 32'h300);
            chk("burst dma_gnt", {31'd0, dma_gnt}, {31'd0, i >= 4});
        end
        drive(4'hF, 1'b0, 32'h40, 1'b1, 4'h0, 32'h300);
        chk("preRst dma_gnt", {31'd0, dma_gnt}, 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("async cpu_stall", {31'd0, cpu_stall}, 32'd0);
        chk("async dma_gnt", {31'd0, dma_gnt}, 32'd0);
        chk("async dma_rvalid", {31'd0, dma_rvalid}, 32'd0);
        chk("async mem_write_en", {28'd0, mem_write_en}, 32'd0);
        chk("async mem_read_en", {31'd0, mem_read_en}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #2;
        chk("post cpu_stall", {31'd0, cpu_stall}, 32'd0);
        chk("post dma_gnt", {31'd0, dma_gnt}, 32'd0);
        chk("post dma_rvalid", {31'd0, dma_rvalid}, 32'd0);
        chk("post mem_write_en", {28'd0, mem_write_en}, 32'hF);
        for (int i = 1; i < 5; i++) begin
            drive(4'hF, 1'b0, 32'h40, 1'b1, 4'h0, 32'h300);
            chk("post wait dma_gnt", {31'd0, dma_gnt}, {31'd0, i == 4});
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
